ndi_band_decoder: RTL and testbench

//  Inverse of the normalized-difference index stage. Takes two 4-bit NDI

---
 rtl/ndi_band_decoder.sv | 119 +++++++++++
 tb/tb_ndi_band_decoder.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/ndi_band_decoder.sv
// NDI band decoder: rebuilds (A,C) and (B,D) band pairs from 4-bit NDI codes and band sums
// using a serial shift-add multiply, with valid/ready handshakes on input and output.
module ndi_band_decoder #(
    parameter int CODE_W = 4,
    parameter int DATA_W = 4,
    parameter int SUM_W  = DATA_W + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CODE_W-1:0] m_code,
    input  logic [CODE_W-1:0] n_code,
    input  logic [SUM_W-1:0]  sum_ac,
    input  logic [SUM_W-1:0]  sum_bd,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] a,
    output logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] c,
    output logic [DATA_W-1:0] d,
    output logic              sat
);

    localparam int P_W   = SUM_W + CODE_W;
    localparam int CNT_W = (CODE_W > 1) ? $clog2(CODE_W) : 1;
    localparam logic [SUM_W-1:0] DMAX = SUM_W'((1 << DATA_W) - 1);
    localparam logic [P_W-1:0]   HALF = P_W'(1 << (CODE_W - 1));

    typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

    state_t             state, state_nxt;
    logic [CODE_W-1:0]  m_q, n_q;
    logic [SUM_W-1:0]   sac_q, sbd_q;
    logic [P_W-1:0]     acc_ac, acc_bd, acc_ac_nxt, acc_bd_nxt;
    logic [CNT_W-1:0]   cnt;
    logic               last;
    logic [SUM_W-1:0]   a_raw, c_raw, b_raw, d_raw;
    logic               a_clp, c_clp, b_clp, d_clp;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign last      = (cnt == CNT_W'(CODE_W - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid)  state_nxt = MUL;
            MUL:     if (last)      state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // One partial product per cycle; final rounding works on the next-accumulator value
    // so the result registers load on the same edge as the last partial product.
    always_comb begin
        acc_ac_nxt = acc_ac + (m_q[cnt] ? (P_W'(sac_q) << cnt) : '0);
        acc_bd_nxt = acc_bd + (n_q[cnt] ? (P_W'(sbd_q) << cnt) : '0);
        a_raw = SUM_W'((acc_ac_nxt + HALF) >> CODE_W);
        b_raw = SUM_W'((acc_bd_nxt + HALF) >> CODE_W);
        c_raw = sac_q - a_raw;
        d_raw = sbd_q - b_raw;
        a_clp = (a_raw > DMAX);
        c_clp = (c_raw > DMAX);
        b_clp = (b_raw > DMAX);
        d_clp = (d_raw > DMAX);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_q    <= '0;
            n_q    <= '0;
            sac_q  <= '0;
            sbd_q  <= '0;
            acc_ac <= '0;
            acc_bd <= '0;
            cnt    <= '0;
            a      <= '0;
            b      <= '0;
            c      <= '0;
            d      <= '0;
            sat    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        m_q    <= m_code;
                        n_q    <= n_code;
                        sac_q  <= sum_ac;
                        sbd_q  <= sum_bd;
                        acc_ac <= '0;
                        acc_bd <= '0;
                        cnt    <= '0;
                    end
                end
                MUL: begin
                    acc_ac <= acc_ac_nxt;
                    acc_bd <= acc_bd_nxt;
                    cnt    <= cnt + CNT_W'(1);
                    if (last) begin
                        a   <= a_clp ? DATA_W'(DMAX) : DATA_W'(a_raw);
                        c   <= c_clp ? DATA_W'(DMAX) : DATA_W'(c_raw);
                        b   <= b_clp ? DATA_W'(DMAX) : DATA_W'(b_raw);
                        d   <= d_clp ? DATA_W'(DMAX) : DATA_W'(d_raw);
                        sat <= a_clp | c_clp | b_clp | d_clp;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ndi_band_decoder.sv
// Self-checking bench for ndi_band_decoder: directed vectors with hand-computed results,
// stall, abort-by-reset and back-to-back random operation against an integer model.
module tb_ndi_band_decoder;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [3:0] m_code = '0, n_code = '0;
    logic [4:0] sum_ac = '0, sum_bd = '0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [3:0] a, b, c, d;
    logic       sat;

    int n_pass = 0;
    int n_chk  = 0;
    int cyc    = 0;

    ndi_band_decoder dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .m_code(m_code), .n_code(n_code), .sum_ac(sum_ac), .sum_bd(sum_bd),
        .out_valid(out_valid), .out_ready(out_ready),
        .a(a), .b(b), .c(c), .d(d), .sat(sat)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // Independent integer reference: round-half-up of S*q/16, then clamp to 15.
    function automatic void model(input int q, input int s, output int x, output int y, output bit clp);
        int xr, yr;
        xr  = (s * q + 8) / 16;
        yr  = s - xr;
        clp = (xr > 15) || (yr > 15);
        x   = (xr > 15) ? 15 : xr;
        y   = (yr > 15) ? 15 : yr;
    endfunction

    task automatic check_out(input string tag, input int ea, input int ec, input int eb,
                             input int ed, input int es);
        chk({tag, ".a"}, a, ea);
        chk({tag, ".c"}, c, ec);
        chk({tag, ".b"}, b, eb);
        chk({tag, ".d"}, d, ed);
        chk({tag, ".sat"}, sat, es);
    endtask

    // Presents one operand set, checks latency, result, optional stall, and release.
    task automatic run_op(input string tag, input int m, input int sa, input int n, input int sb,
                          input int ea, input int ec, input int eb, input int ed, input int es,
                          input int hold);
        int lat;
        int w;
        @(negedge clk);
        in_valid = 1'b1;
        m_code = 4'(m); sum_ac = 5'(sa); n_code = 4'(n); sum_bd = 5'(sb);
        out_ready = (hold == 0);
        w = 0;
        while (!in_ready && w < 20) begin @(negedge clk); w++; end
        chk({tag, ".in_ready"}, in_ready, 1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        m_code = ~m_code; sum_ac = ~sum_ac; n_code = ~n_code; sum_bd = ~sum_bd;
        lat = 0;
        while (!out_valid && lat < 20) begin @(negedge clk); lat++; end
        chk({tag, ".latency"}, lat, 4);
        check_out(tag, ea, ec, eb, ed, es);
        chk({tag, ".busy"}, in_ready, 0);
        if (hold > 0) begin
            for (int i = 0; i < hold; i++) begin
                @(negedge clk);
                chk({tag, ".hold_valid"}, out_valid, 1);
                chk({tag, ".hold_busy"}, in_ready, 0);
                chk({tag, ".hold_a"}, a, ea);
            end
            check_out({tag, ".held"}, ea, ec, eb, ed, es);
            out_ready = 1'b1;
        end
        @(negedge clk);
        chk({tag, ".released"}, out_valid, 0);
        chk({tag, ".idle"}, in_ready, 1);
    endtask

    initial begin
        int ov_seen;
        int w;
        int prev_cyc;
        int ma[8], sa[8], nb[8], sb[8];
        int ea, ec, eb, ed;
        bit ca, cb;

        // reset with in_valid asserted must not start anything
        in_valid = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst.in_ready", in_ready, 1);
        chk("rst.out_valid", out_valid, 0);
        check_out("rst", 0, 0, 0, 0, 0);
        in_valid = 1'b0;
        rst = 1'b0;
        @(negedge clk);

        run_op("t1", 8, 10, 8, 6, 5, 5, 3, 3, 0, 0);
        run_op("t2", 12, 20, 4, 16, 15, 5, 4, 12, 0, 0);
        run_op("t3", 15, 30, 0, 30, 15, 2, 0, 15, 1, 0);
        run_op("s0_s31", 5, 0, 15, 31, 0, 0, 15, 2, 1, 0);
        run_op("q0_noclamp", 0, 12, 15, 16, 0, 12, 15, 1, 0, 0);
        run_op("t4_stall", 3, 21, 10, 9, 4, 15, 6, 3, 1, 10);
        // new op accepted the cycle after release
        run_op("t4_next", 8, 10, 8, 6, 5, 5, 3, 3, 0, 0);

        // abort by reset two cycles after accept
        @(negedge clk);
        in_valid = 1'b1; out_ready = 1'b1;
        m_code = 4'd12; sum_ac = 5'd20; n_code = 4'd4; sum_bd = 5'd16;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_out("t5.rst", 0, 0, 0, 0, 0);
        chk("t5.rst_valid", out_valid, 0);
        @(negedge clk);
        rst = 1'b0;
        ov_seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (out_valid) ov_seen++;
        end
        chk("t5.no_out_valid", ov_seen, 0);
        chk("t5.in_ready", in_ready, 1);
        check_out("t5.after", 0, 0, 0, 0, 0);

        // back-to-back random stream
        for (int k = 0; k < 8; k++) begin
            ma[k] = $urandom_range(15); sa[k] = $urandom_range(31);
            nb[k] = $urandom_range(15); sb[k] = $urandom_range(31);
        end
        @(negedge clk);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        m_code = 4'(ma[0]); sum_ac = 5'(sa[0]); n_code = 4'(nb[0]); sum_bd = 5'(sb[0]);
        prev_cyc = 0;
        for (int k = 0; k < 8; k++) begin
            w = 0;
            while (in_ready && w < 20) begin @(negedge clk); w++; end
            if (k < 7) begin
                m_code = 4'(ma[k+1]); sum_ac = 5'(sa[k+1]);
                n_code = 4'(nb[k+1]); sum_bd = 5'(sb[k+1]);
            end else begin
                in_valid = 1'b0;
            end
            w = 0;
            while (!out_valid && w < 20) begin @(negedge clk); w++; end
            chk("t6.valid", out_valid, 1);
            model(ma[k], sa[k], ea, ec, ca);
            model(nb[k], sb[k], eb, ed, cb);
            check_out($sformatf("t6[%0d]", k), ea, ec, eb, ed, int'(ca | cb));
            if (k > 0) chk("t6.period", cyc - prev_cyc, 6);
            prev_cyc = cyc;
            w = 0;
            while (out_valid && w < 20) begin @(negedge clk); w++; end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
